fwvexrisc_rvfi_trace_fifo: RTL and testbench
============================================

Name: fwvexrisc_rvfi_trace_fifo

Overview:
- Retirement-trace buffer between the VexRiscv RVFI port and the RISC-V debug BFM.
- Captures each retired-instruction RVFI record and normalises it.
- Checks that rvfi_order is contiguous.
- Delivers records in order over a valid/ready interface, so the BFM side may stall without losing retirements.
- Provides overflow and ordering error status for the testbench.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CHECK_ORDER, 1, 1 enables the rvfi_order continuity check; 0 holds order_err and order_err_count at 0.

Ports:
- clock  in  1  sole clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- rvfi_valid  in  1  retirement strobe
- rvfi_order  in  64  retirement sequence number
- rvfi_insn  in  32  instruction word
- rvfi_trap  in  1  trap flag
- rvfi_intr  in  1  first instruction of a trap handler
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- rvfi_pc_rdata  in  32  PC of the retired instruction
- rvfi_mem_addr  in  32  memory address
- rvfi_mem_rmask  in  4  memory read byte mask
- rvfi_mem_wmask  in  4  memory write byte mask
- rvfi_mem_wdata  in  32  memory write data
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts the head record
- out_insn, out_trap, out_intr, out_rd_addr, out_rd_wdata, out_pc, out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_data  out  32,1,1,5,32,32,32,4,4,32  head record fields
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one record was dropped
- drop_count  out  16  records dropped; saturates at 16'hFFFF
- order_err  out  1  sticky: an order discontinuity was seen
- order_err_count  out  16  number of discontinuities; saturates

Behaviour:
- Reset (synchronous, active-high): all outputs 0, including every out_* field, level, the status flags and the counters. FIFO emptied; expected_order set to 0. Reset asserted mid-stream discards all buffered records on that edge.
- Push: rvfi_valid=1 and (level<DEPTH, or pop in the same cycle) writes one record at the tail. Record is visible at the head no earlier than the next cycle; minimum latency is 1 cycle from rvfi_valid to out_valid.
- Normalisation at push:
  - rd_addr==0 forces stored rd_wdata=0.
  - rmask==0 and wmask==0 forces stored mem_addr=0 and mem_data=0.
  - mem_data is taken from rvfi_mem_wdata.
- Drop: rvfi_valid=1, level==DEPTH and no pop in the same cycle. The record is discarded, overflow is set, and drop_count increments (saturating). The order check still runs on dropped records.
- Pop: out_valid and out_ready. Head advances; out_* change only on a pop or on an empty-to-non-empty transition. out_* hold stable while out_valid=1 and out_ready=0.
- Empty: out_valid=0 and out_* hold their last values. out_ready is ignored.
- Simultaneous push and pop: level unchanged. Legal at level==DEPTH (no drop). At level==1 the new record becomes the head on the next cycle.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. level is exact with no off-by-one at full.
- Order check (CHECK_ORDER=1), on every rvfi_valid:
  - If rvfi_order != expected_order, set order_err and increment order_err_count (saturating).
  - Always expected_order <= rvfi_order+1 (64-bit wrap). The checker therefore resynchronises after an error.
- overflow and order_err clear only on reset.

Test Plan:
- Reset, then 3 pushes (order 0,1,2; pc 0x80000000/4/8) with out_ready=1 -> three out_valid pulses in order, each 1 cycle after its push; level returns to 0; no error flags.
- DEPTH=8, out_ready=0, 10 pushes order 0..9 -> level=8, overflow=1, drop_count=2. With out_ready=1, pops return orders 0..7 (pc checks) then out_valid=0.
- Full FIFO with push and pop in the same cycle -> level stays 8, drop_count unchanged, the pushed record is delivered 8th.
- Push order 0,1,5,6 -> order_err=1 and order_err_count=1 after order 5; no further increment on 6.
- Push rd_addr=0 with rd_wdata=0xDEADBEEF and masks 0 with mem_addr=0x1000 -> out_rd_wdata=0 and out_mem_addr=0. Push rd_addr=5 with wmask=4'hF and mem_wdata=0x12345678 -> values pass through unchanged.
- Reset asserted with level=5 while pushing -> next cycle level=0, out_valid=0, counters 0; a subsequent push with order 0 gives no order_err.

Source files
------------

// File: rtl/fwvexrisc_rvfi_trace_fifo.sv
// RVFI retirement-trace FIFO: normalises each retired record, checks rvfi_order
// continuity and delivers records in order over valid/ready with drop accounting.
module fwvexrisc_rvfi_trace_fifo #(
   parameter int DEPTH       = 8,
   parameter bit CHECK_ORDER = 1'b1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       rvfi_valid,
   input  logic [63:0]                rvfi_order,
   input  logic [31:0]                rvfi_insn,
   input  logic                       rvfi_trap,
   input  logic                       rvfi_intr,
   input  logic [4:0]                 rvfi_rd_addr,
   input  logic [31:0]                rvfi_rd_wdata,
   input  logic [31:0]                rvfi_pc_rdata,
   input  logic [31:0]                rvfi_mem_addr,
   input  logic [3:0]                 rvfi_mem_rmask,
   input  logic [3:0]                 rvfi_mem_wmask,
   input  logic [31:0]                rvfi_mem_wdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_insn,
   output logic                       out_trap,
   output logic                       out_intr,
   output logic [4:0]                 out_rd_addr,
   output logic [31:0]                out_rd_wdata,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_mem_addr,
   output logic [3:0]                 out_mem_rmask,
   output logic [3:0]                 out_mem_wmask,
   output logic [31:0]                out_mem_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [15:0]                drop_count,
   output logic                       order_err,
   output logic [15:0]                order_err_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic [31:0] insn;
      logic        trap;
      logic        intr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] pc;
      logic [31:0] mem_addr;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
      logic [31:0] mem_data;
   } rec_t;

   rec_t          mem [DEPTH];
   rec_t          in_rec;
   rec_t          head_reg;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
   logic [LW-1:0] level_reg;
   logic          overflow_reg;
   logic [15:0]   drop_count_reg;
   logic          pop, push, drop, full, empty;

   assign empty      = (level_reg == '0);
   assign full       = (level_reg == LW'(DEPTH));
   assign pop        = !empty && out_ready;
   assign push       = rvfi_valid && (!full || pop);
   assign drop       = rvfi_valid && full && !pop;
   assign rd_ptr_inc = rd_ptr_reg + PW'(1);

   // Records without a real destination or memory access carry no stale data.
   always_comb begin
      in_rec           = '0;
      in_rec.insn      = rvfi_insn;
      in_rec.trap      = rvfi_trap;
      in_rec.intr      = rvfi_intr;
      in_rec.rd_addr   = rvfi_rd_addr;
      in_rec.rd_wdata  = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
      in_rec.pc        = rvfi_pc_rdata;
      in_rec.mem_rmask = rvfi_mem_rmask;
      in_rec.mem_wmask = rvfi_mem_wmask;
      if ((rvfi_mem_rmask != 4'd0) || (rvfi_mem_wmask != 4'd0)) begin
         in_rec.mem_addr = rvfi_mem_addr;
         in_rec.mem_data = rvfi_mem_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !reset)
         mem[wr_ptr_reg] <= in_rec;
   end

   // Head register: bypass the incoming record when it becomes the head directly,
   // otherwise fetch the next stored entry on a pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_reg <= '0;
      end else if (push && (empty || (pop && level_reg == LW'(1)))) begin
         head_reg <= in_rec;
      end else if (pop && level_reg > LW'(1)) begin
         head_reg <= mem[rd_ptr_inc];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         level_reg      <= '0;
         overflow_reg   <= 1'b0;
         drop_count_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_inc;
         if (push && !pop)
            level_reg <= level_reg + LW'(1);
         else if (pop && !push)
            level_reg <= level_reg - LW'(1);
         if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_count_reg != 16'hFFFF)
               drop_count_reg <= drop_count_reg + 16'd1;
         end
      end
   end

   generate
      if (CHECK_ORDER) begin : g_order
         logic [63:0] expected_order_reg;
         logic        order_err_reg;
         logic [15:0] order_err_count_reg;

         // Resynchronise on every retirement so one gap counts once.
         always_ff @(posedge clock) begin
            if (reset) begin
               expected_order_reg  <= '0;
               order_err_reg       <= 1'b0;
               order_err_count_reg <= '0;
            end else if (rvfi_valid) begin
               expected_order_reg <= rvfi_order + 64'd1;
               if (rvfi_order != expected_order_reg) begin
                  order_err_reg <= 1'b1;
                  if (order_err_count_reg != 16'hFFFF)
                     order_err_count_reg <= order_err_count_reg + 16'd1;
               end
            end
         end

         assign order_err       = order_err_reg;
         assign order_err_count = order_err_count_reg;
      end else begin : g_no_order
         assign order_err       = 1'b0;
         assign order_err_count = 16'd0;
      end
   endgenerate

   assign out_valid     = !empty;
   assign out_insn      = head_reg.insn;
   assign out_trap      = head_reg.trap;
   assign out_intr      = head_reg.intr;
   assign out_rd_addr   = head_reg.rd_addr;
   assign out_rd_wdata  = head_reg.rd_wdata;
   assign out_pc        = head_reg.pc;
   assign out_mem_addr  = head_reg.mem_addr;
   assign out_mem_rmask = head_reg.mem_rmask;
   assign out_mem_wmask = head_reg.mem_wmask;
   assign out_mem_data  = head_reg.mem_data;
   assign level         = level_reg;
   assign overflow      = overflow_reg;
   assign drop_count    = drop_count_reg;
endmodule

// File: tb/tb_fwvexrisc_rvfi_trace_fifo.sv
// Directed bench for the RVFI trace FIFO: stimulus pushes expected records into a
// scoreboard queue, a negedge monitor pops and compares every delivered record.
module tb_fwvexrisc_rvfi_trace_fifo;
   typedef struct packed {
      logic [31:0] insn;
      logic        trap;
      logic        intr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] pc;
      logic [31:0] mem_addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] mem_data;
   } rec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rvfi_valid = 1'b0;
   logic [63:0] rvfi_order = '0;
   logic [31:0] rvfi_insn = '0;
   logic        rvfi_trap = 1'b0;
   logic        rvfi_intr = 1'b0;
   logic [4:0]  rvfi_rd_addr = '0;
   logic [31:0] rvfi_rd_wdata = '0;
   logic [31:0] rvfi_pc_rdata = '0;
   logic [31:0] rvfi_mem_addr = '0;
   logic [3:0]  rvfi_mem_rmask = '0;
   logic [3:0]  rvfi_mem_wmask = '0;
   logic [31:0] rvfi_mem_wdata = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_insn, out_rd_wdata, out_pc, out_mem_addr, out_mem_data;
   logic        out_trap, out_intr;
   logic [4:0]  out_rd_addr;
   logic [3:0]  out_mem_rmask, out_mem_wmask;
   logic [3:0]  level;
   logic        overflow, order_err;
   logic [15:0] drop_count, order_err_count;

   int n_cmp = 0;
   int n_err = 0;
   rec_t exp_q[$];

   fwvexrisc_rvfi_trace_fifo #(.DEPTH(8), .CHECK_ORDER(1'b1)) dut (
      .clock(clock), .reset(reset),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
      .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_rd_addr(rvfi_rd_addr),
      .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
      .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
      .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_wdata(rvfi_mem_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_insn(out_insn), .out_trap(out_trap), .out_intr(out_intr),
      .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata), .out_pc(out_pc),
      .out_mem_addr(out_mem_addr), .out_mem_rmask(out_mem_rmask),
      .out_mem_wmask(out_mem_wmask), .out_mem_data(out_mem_data),
      .level(level), .overflow(overflow), .drop_count(drop_count),
      .order_err(order_err), .order_err_count(order_err_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a transfer happens on the next rising edge whenever valid && ready.
   always @(negedge clock) begin
      rec_t act, exp;
      if (!reset && out_valid && out_ready) begin
         act = '{out_insn, out_trap, out_intr, out_rd_addr, out_rd_wdata, out_pc,
                 out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_data};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got pc 0x%08h expected no record", out_pc);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               n_err++;
               $display("FAIL pop_record: got %h expected %h", act, exp);
            end else begin
               $display("pop pc=0x%08h insn=0x%08h rd_wdata=0x%08h mem_addr=0x%08h",
                        out_pc, out_insn, out_rd_wdata, out_mem_addr);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      cycle();
      reset = 1'b0;
   endtask

   function automatic rec_t simple(input logic [31:0] pc);
      rec_t r;
      r = '0;
      r.insn     = 32'h0000_0013;
      r.rd_addr  = 5'd1;
      r.rd_wdata = pc + 32'd1;
      r.pc       = pc;
      return r;
   endfunction

   // Drive one retirement; exp is queued only when the FIFO is expected to accept it.
   task automatic push(input logic [63:0] ord, input rec_t r, input rec_t e, input bit accept);
      rvfi_valid     = 1'b1;
      rvfi_order     = ord;
      rvfi_insn      = r.insn;
      rvfi_trap      = r.trap;
      rvfi_intr      = r.intr;
      rvfi_rd_addr   = r.rd_addr;
      rvfi_rd_wdata  = r.rd_wdata;
      rvfi_pc_rdata  = r.pc;
      rvfi_mem_addr  = r.mem_addr;
      rvfi_mem_rmask = r.rmask;
      rvfi_mem_wmask = r.wmask;
      rvfi_mem_wdata = r.mem_data;
      if (accept)
         exp_q.push_back(e);
      $display("push order=%0d pc=0x%08h accept=%0d", ord, r.pc, accept);
      cycle();
      rvfi_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t r, e;
      cycle();
      cycle();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_level", level, 0);
      chk("reset_flags", {overflow, order_err}, 0);
      chk("reset_counts", {drop_count, order_err_count}, 0);
      chk("reset_out_pc", out_pc, 0);
      reset = 1'b0;

      // Streaming: each record appears one cycle after its push.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         r = simple(32'h8000_0000 + 32'(4 * i));
         push(64'(i), r, r, 1'b1);
         chk("stream_latency_valid", out_valid, 1);
         chk("stream_level", level, 1);
      end
      cycle();
      chk("stream_drained_level", level, 0);
      chk("stream_no_flags", {overflow, order_err}, 0);

      // Fill beyond depth with the consumer stalled.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         r = simple(32'h8000_0000 + 32'(4 * i));
         push(64'(i), r, r, i < 8);
      end
      chk("full_level", level, 8);
      chk("full_overflow", overflow, 1);
      chk("full_drop_count", drop_count, 2);
      chk("full_head_stable_pc", out_pc, 32'h8000_0000);

      // Push and pop together at full: no drop, record lands behind orders 1..7.
      out_ready = 1'b1;
      r = simple(32'h8000_0028);
      push(64'd10, r, r, 1'b1);
      chk("pushpop_full_level", level, 8);
      chk("pushpop_drop_count", drop_count, 2);
      chk("pushpop_no_order_err", order_err, 0);
      repeat (9) cycle();
      chk("drain_out_valid", out_valid, 0);
      chk("drain_level", level, 0);
      chk("drain_queue_empty", exp_q.size(), 0);

      // Order gap 1 -> 5 counts once, resynchronises at 6.
      do_reset();
      push(64'd0, simple(32'h100), simple(32'h100), 1'b1);
      push(64'd1, simple(32'h104), simple(32'h104), 1'b1);
      chk("order_before_gap", order_err, 0);
      push(64'd5, simple(32'h108), simple(32'h108), 1'b1);
      chk("order_err_set", order_err, 1);
      chk("order_err_count_1", order_err_count, 1);
      push(64'd6, simple(32'h10C), simple(32'h10C), 1'b1);
      chk("order_err_count_hold", order_err_count, 1);

      // Normalisation: rd_addr 0 and no memory access clear the data fields.
      r = '{32'h0000_0033, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h200, 32'h1000, 4'h0, 4'h0, 32'hCAFE_F00D};
      e = '{32'h0000_0033, 1'b0, 1'b0, 5'd0, 32'h0, 32'h200, 32'h0, 4'h0, 4'h0, 32'h0};
      push(64'd7, r, e, 1'b1);
      r = '{32'h0050_2023, 1'b1, 1'b1, 5'd5, 32'h0000_00AA, 32'h204, 32'h2000, 4'h0, 4'hF, 32'h1234_5678};
      push(64'd8, r, r, 1'b1);
      cycle();
      chk("norm_drained", level, 0);

      // Reset mid-stream with a push on the same edge.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push(64'(i), simple(32'h300 + 32'(4 * i)), simple(32'h300 + 32'(4 * i)), 1'b1);
      chk("pre_reset_level", level, 5);
      rvfi_valid = 1'b1;
      rvfi_order = 64'd5;
      reset = 1'b1;
      exp_q.delete();
      cycle();
      reset = 1'b0;
      rvfi_valid = 1'b0;
      chk("midreset_level", level, 0);
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_counts", {drop_count, order_err_count}, 0);
      chk("midreset_out_pc", out_pc, 0);
      out_ready = 1'b1;
      push(64'd0, simple(32'h400), simple(32'h400), 1'b1);
      chk("post_reset_valid", out_valid, 1);
      chk("post_reset_order_err", order_err, 0);
      cycle();
      chk("post_reset_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
